// File: rtl/mips_datapath_if.sv
// Instruction, control and debug bus for the single-cycle MIPS datapath.
interface mips_datapath_if;
    logic [31:0] inst;
    logic        RegDst;
    logic        RegWrite;
    logic        ALUSrc;
    logic [3:0]  ALUcontrol;
    logic        MemWrite;
    logic        MemRead;
    logic        MemToReg;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic [31:0] alu_result;
    logic        zero;
    logic [31:0] mem_read_data;
    logic [31:0] write_back_data;

    modport master (
        output inst, RegDst, RegWrite, ALUSrc, ALUcontrol, MemWrite, MemRead, MemToReg,
        input  read_data1, read_data2, alu_result, zero, mem_read_data, write_back_data
    );

    modport slave (
        input  inst, RegDst, RegWrite, ALUSrc, ALUcontrol, MemWrite, MemRead, MemToReg,
        output read_data1, read_data2, alu_result, zero, mem_read_data, write_back_data
    );
endinterface

// File: rtl/mips_datapath.sv
// Single-cycle MIPS datapath: register file, ALU, sign extender, data memory
// and write-back mux; control comes from an external decoder.
module mips_datapath #(
    parameter int unsigned DMEM_DEPTH = 64,
    parameter int unsigned DMEM_AW    = 6
) (
    input logic            clk,
    input logic            rst_n,
    mips_datapath_if.slave bus
);
    logic [4:0]         rs, rt, rd, wa;
    logic [15:0]        imm;
    logic [31:0]        imm_ext, alu_b, alu_res, rd1, rd2, mrd, wb;
    logic [DMEM_AW-1:0] idx;
    logic [31:0]        regs [32];
    logic [31:0]        dmem [DMEM_DEPTH];

    assign rs      = bus.inst[25:21];
    assign rt      = bus.inst[20:16];
    assign rd      = bus.inst[15:11];
    assign imm     = bus.inst[15:0];
    assign imm_ext = {{16{imm[15]}}, imm};
    assign wa      = bus.RegDst ? rd : rt;

    assign rd1 = (rs == 5'd0) ? '0 : regs[rs];
    assign rd2 = (rt == 5'd0) ? '0 : regs[rt];

    assign alu_b = bus.ALUSrc ? imm_ext : rd2;

    always_comb begin
        alu_res = '0;
        case (bus.ALUcontrol)
            4'b0000: alu_res = rd1 & alu_b;
            4'b0001: alu_res = rd1 | alu_b;
            4'b0010: alu_res = rd1 + alu_b;
            4'b0110: alu_res = rd1 - alu_b;
            4'b0111: alu_res = ($signed(rd1) < $signed(alu_b)) ? 32'd1 : 32'd0;
            4'b1100: alu_res = ~(rd1 | alu_b);
            default: alu_res = '0;
        endcase
    end

    // Byte offset and upper address bits are dropped, so addresses wrap.
    assign idx = alu_res[DMEM_AW+1:2];
    assign mrd = bus.MemRead ? dmem[idx] : '0;
    assign wb  = bus.MemToReg ? mrd : alu_res;

    // Reset seeds register k with k so tests have known operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < 32; k++)
                regs[k] <= k;
        end else if (bus.RegWrite && (wa != 5'd0)) begin
            regs[wa] <= wb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < DMEM_DEPTH; k++)
                dmem[k] <= '0;
        end else if (bus.MemWrite) begin
            dmem[idx] <= rd2;
        end
    end

    assign bus.read_data1      = rd1;
    assign bus.read_data2      = rd2;
    assign bus.alu_result      = alu_res;
    assign bus.zero            = (alu_res == '0);
    assign bus.mem_read_data   = mrd;
    assign bus.write_back_data = wb;

    logic unused_ok;
    assign unused_ok = &{1'b0, bus.inst[31:26], bus.inst[10:0], alu_res[1:0], alu_res[31:DMEM_AW+2]};
endmodule

// File: tb/tb_mips_datapath.sv
// Self-checking bench for mips_datapath: directed test-plan steps plus random
// instructions checked against an architectural model of registers and memory.
module tb_mips_datapath;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    mips_datapath_if bus();

    mips_datapath #(.DMEM_DEPTH(64), .DMEM_AW(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural state as the instruction set defines it.
    logic [31:0] m_reg [32];
    logic [31:0] m_mem [64];

    // Expected results of the instruction currently applied.
    logic [31:0] e_alu, e_mrd, e_wb, e_rd2;
    logic [4:0]  e_wa;
    int          e_idx;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 32; k++) m_reg[k] = k;
        for (int k = 0; k < 64; k++) m_mem[k] = 32'd0;
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return 32'((longint'(a) + longint'(b)) % 64'h1_0000_0000);
            4'd6:  return 32'((longint'(a) - longint'(b) + 64'h1_0000_0000) % 64'h1_0000_0000);
            4'd7:  return (sa < sb) ? 32'd1 : 32'd0;
            4'd12: return ~(a | b);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] rtype(input int s, input int t, input int d);
        logic [31:0] v;
        v = 32'd0;
        v[25:21] = 5'(s);
        v[20:16] = 5'(t);
        v[15:11] = 5'(d);
        v[5:0]   = 6'h20;
        return v;
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] opc, input int s, input int t, input logic [15:0] im);
        return {opc, 5'(s), 5'(t), im};
    endfunction

    task automatic drive(input logic [31:0] i, input logic rdst, input logic rw, input logic asrc,
                         input logic [3:0] op, input logic mw, input logic mr, input logic m2r);
        bus.inst = i; bus.RegDst = rdst; bus.RegWrite = rw; bus.ALUSrc = asrc;
        bus.ALUcontrol = op; bus.MemWrite = mw; bus.MemRead = mr; bus.MemToReg = m2r;
    endtask

    // Drive one instruction mid-cycle and check every combinational output.
    task automatic apply(input logic [31:0] i, input logic rdst, input logic rw, input logic asrc,
                         input logic [3:0] op, input logic mw, input logic mr, input logic m2r);
        logic [31:0] a, b;
        int s, t;
        @(negedge clk);
        drive(i, rdst, rw, asrc, op, mw, mr, m2r);
        #1;
        s = int'(i[25:21]);
        t = int'(i[20:16]);
        a = m_reg[s];
        e_rd2 = m_reg[t];
        b = asrc ? 32'($signed(i[15:0])) : e_rd2;
        e_alu = ref_alu(op, a, b);
        e_idx = int'(e_alu % 256) / 4;
        e_mrd = mr ? m_mem[e_idx] : 32'd0;
        e_wb  = m2r ? e_mrd : e_alu;
        e_wa  = rdst ? i[15:11] : i[20:16];
        chk("read_data1", bus.read_data1, a);
        chk("read_data2", bus.read_data2, e_rd2);
        chk("alu_result", bus.alu_result, e_alu);
        chk("zero", 32'(bus.zero), (e_alu == 32'd0) ? 32'd1 : 32'd0);
        chk("mem_read_data", bus.mem_read_data, e_mrd);
        chk("write_back_data", bus.write_back_data, e_wb);
    endtask

    // Commit the applied instruction at the next rising edge.
    task automatic clock();
        @(posedge clk);
        #1;
        if (bus.MemWrite) m_mem[e_idx] = e_rd2;
        if (bus.RegWrite && e_wa != 5'd0) m_reg[e_wa] = e_wb;
    endtask

    // Pure reads with all write enables off, safe at any point in the cycle.
    task automatic peek_reg(input int k);
        drive(rtype(k, k, 0), 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk($sformatf("reg%0d_rs", k), bus.read_data1, m_reg[k]);
        chk($sformatf("reg%0d_rt", k), bus.read_data2, m_reg[k]);
    endtask

    task automatic peek_mem(input int k);
        drive(itype(6'h23, 0, 0, 16'(4 * k)), 1'b0, 1'b0, 1'b1, 4'd2, 1'b0, 1'b1, 1'b0);
        #1;
        chk($sformatf("mem%0d", k), bus.mem_read_data, m_mem[k]);
    endtask

    task automatic peek_all();
        for (int k = 0; k < 32; k++) peek_reg(k);
        for (int k = 0; k < 64; k++) peek_mem(k);
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(32'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] ops [7];
        logic [31:0] ri;
        logic [3:0] rop;
        tests = 0;
        fails = 0;
        ops[0] = 4'd0; ops[1] = 4'd1; ops[2] = 4'd2; ops[3] = 4'd6;
        ops[4] = 4'd7; ops[5] = 4'd12; ops[6] = 4'd5;
        rst_n = 1'b1;
        drive(32'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        model_reset();

        // Reset state
        do_reset();
        peek_all();

        // add $1,$2,$3
        apply(32'h00430820, 1'b1, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0);
        chk("add_alu", bus.alu_result, 32'd5);
        clock();
        peek_reg(1);
        chk("add_writeback", bus.read_data1, 32'd5);

        // sw $3,4($0) then lw $5,4($0)
        do_reset();
        apply(32'hAC030004, 1'b0, 1'b0, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b0);
        clock();
        apply(32'h8C050004, 1'b0, 1'b1, 1'b1, 4'b0010, 1'b0, 1'b1, 1'b1);
        chk("lw_data", bus.mem_read_data, 32'd3);
        clock();
        peek_reg(5);
        chk("lw_writeback", bus.read_data1, 32'd3);

        // sub / slt / nor
        apply(rtype(2, 2, 4), 1'b1, 1'b1, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0);
        chk("sub_alu", bus.alu_result, 32'd0);
        chk("sub_zero", 32'(bus.zero), 32'd1);
        clock();
        apply(rtype(2, 3, 4), 1'b1, 1'b1, 1'b0, 4'b0111, 1'b0, 1'b0, 1'b0);
        chk("slt_true", bus.alu_result, 32'd1);
        clock();
        apply(rtype(3, 2, 4), 1'b1, 1'b1, 1'b0, 4'b0111, 1'b0, 1'b0, 1'b0);
        chk("slt_false", bus.alu_result, 32'd0);
        clock();
        apply(rtype(0, 0, 4), 1'b1, 1'b1, 1'b0, 4'b1100, 1'b0, 1'b0, 1'b0);
        chk("nor", bus.alu_result, 32'hFFFF_FFFF);
        clock();

        // Write to $0 ignored; negative immediate
        apply(rtype(2, 3, 0), 1'b1, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0);
        clock();
        peek_reg(0);
        chk("r0_zero", bus.read_data1, 32'd0);
        apply(itype(6'h23, 8, 9, 16'hFFFC), 1'b0, 1'b1, 1'b1, 4'b0010, 1'b0, 1'b1, 1'b1);
        chk("neg_imm", bus.alu_result, 32'd4);
        clock();

        // Address wrap: byte 0x104 lands on word 1
        apply(itype(6'h2B, 0, 7, 16'h0104), 1'b0, 1'b0, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b0);
        chk("wrap_addr", bus.alu_result, 32'h104);
        clock();
        peek_mem(1);
        chk("wrap_word1", bus.mem_read_data, 32'd7);
        apply(itype(6'h23, 0, 9, 16'h0004), 1'b0, 1'b0, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0);
        chk("memread_off", bus.mem_read_data, 32'd0);
        clock();

        // Random instructions and controls
        for (int n = 0; n < 400; n++) begin
            ri  = $urandom;
            rop = ($urandom_range(0, 3) == 0) ? 4'($urandom) : ops[$urandom_range(0, 6)];
            if ($urandom_range(0, 1) == 1) ri[15:14] = 2'b00;
            apply(ri, 1'($urandom), 1'($urandom), 1'($urandom), rop,
                  1'($urandom), 1'($urandom), 1'($urandom));
            clock();
        end
        peek_all();

        // Mid-cycle reset discards the pending write
        apply(rtype(2, 3, 9), 1'b1, 1'b1, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_rs", bus.read_data1, 32'd2);
        chk("async_rst_alu", bus.alu_result, 32'd5);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        peek_all();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
